// File: rtl/fwd_mux_reg.sv
// Registered N-to-1 forwarding operand select at the ID/EX boundary.
// Adds stall/flush control and a saturating counter of illegal selects.
module fwd_mux_reg #(
    parameter int BITWIDTH    = 32,
    parameter int NUM_IN      = 4,
    parameter int SEL_W       = 2,
    parameter int ERR_CNT_W   = 8,
    parameter int HOLD_ON_ERR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN*BITWIDTH-1:0] din,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       in_valid,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       err_clr,
    output logic [BITWIDTH-1:0]        y,
    output logic                       y_valid,
    output logic [SEL_W-1:0]           y_sel,
    output logic                       sel_err,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    generate
        if (NUM_IN < 2 || NUM_IN > (2 ** SEL_W)) begin : g_bad_cfg
            $error("fwd_mux_reg: NUM_IN must lie in 2..2**SEL_W");
        end
    endgenerate

    // NUM_IN always fits in SEL_W+1 bits, so the legality compare never truncates.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic                sel_legal;
    logic [BITWIDTH-1:0] picked;
    logic                load;
    logic                err_inc;

    assign sel_legal = ({1'b0, sel} < NUM_IN_W);

    // Explicit decode keeps an out-of-range sel from ever indexing past din.
    always_comb begin
        picked = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                picked = din[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    assign load    = !flush && !stall;
    assign err_inc = load && in_valid && !sel_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_sel   <= '0;
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (flush) begin
                y       <= '0;
                y_valid <= 1'b0;
                y_sel   <= '0;
                sel_err <= 1'b0;
            end else if (!stall) begin
                if (!in_valid) begin
                    y_valid <= 1'b0;
                    sel_err <= 1'b0;
                end else if (sel_legal) begin
                    y       <= picked;
                    y_sel   <= sel;
                    y_valid <= 1'b1;
                    sel_err <= 1'b0;
                end else begin
                    if (HOLD_ON_ERR == 0) begin
                        y <= '0;
                    end
                    y_sel   <= sel;
                    y_valid <= 1'b0;
                    sel_err <= 1'b1;
                end
            end

            // Clear wins over a same-cycle increment; the count saturates.
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/fwd_mux_reg.md
Name: fwd_mux_reg

Overview:
Parametrised, registered N-to-1 operand-select stage for the 5-stage pipelined CPU. It generalises the fixed 3-data-input, 2-bit-select forwarding mux in three ways: configurable input count and width, a pipeline register with stall/flush control, and defined handling of illegal selects with an error counter. It sits at the ID/EX boundary and registers the forwarded operand chosen by the hazard unit.

Parameters:
BITWIDTH, 32, data width of each input and of y
NUM_IN, 4, number of data inputs; legal range 2..2**SEL_W
SEL_W, 2, select width
ERR_CNT_W, 8, width of the saturating illegal-select counter
HOLD_ON_ERR, 0, 0: y loads 0 on an illegal select; 1: y keeps its previous value

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
din  input  NUM_IN*BITWIDTH  packed inputs; input i occupies bits [i*BITWIDTH +: BITWIDTH]
sel  input  SEL_W  input index
in_valid  input  1  sel/din qualify an operand this cycle
stall  input  1  hold the stage register
flush  input  1  kill the stage contents
err_clr  input  1  clear err_cnt
y  output  BITWIDTH  registered selected operand
y_valid  output  1  y holds a valid operand
y_sel  output  SEL_W  registered copy of the sel that produced y
sel_err  output  1  registered flag: the stage holds an illegal-select result
err_cnt  output  ERR_CNT_W  saturating count of accepted illegal selects

Behaviour:
- All outputs are registered. Latency from din/sel to y is exactly 1 cycle. There is no combinational path from any input to any output.
- The stage has no FSM. Each clock edge applies the first matching case, in this priority order: rst > flush > stall > load.
- rst: y=0, y_valid=0, y_sel=0, sel_err=0, err_cnt=0. A reset asserted mid-stream discards the stage contents.
- flush: y_valid=0, sel_err=0, y=0, y_sel=0.
  - flush overrides stall.
  - err_cnt does not change, except that err_clr is still honoured.
- stall (without flush): y, y_valid, y_sel and sel_err hold their values. Inputs are ignored, and err_cnt does not increment.
- load (no rst, flush or stall):
  - in_valid=0: y_valid=0, sel_err=0. y and y_sel hold their values.
  - in_valid=1 and sel<NUM_IN: y=din[sel], y_sel=sel, y_valid=1, sel_err=0.
  - in_valid=1 and sel>=NUM_IN (illegal):
    - y_valid=0, sel_err=1, y_sel=sel.
    - y=0 when HOLD_ON_ERR=0; y holds its value when HOLD_ON_ERR=1.
    - err_cnt increments by 1 and saturates at 2**ERR_CNT_W-1 (no wrap).
- X is never driven on y. The illegal-select case always yields a defined value.
- err_clr:
  - err_clr sets err_cnt=0 on any edge without rst. It overrides a same-cycle increment: the result is 0, not 1.
  - err_clr does not affect the stage register.
- When NUM_IN==2**SEL_W, no select value is illegal; sel_err and err_cnt stay 0.
- Elaboration check: NUM_IN<2 or NUM_IN>2**SEL_W is a configuration error and must fail elaboration.

Test Plan:
- Reset and basic select (defaults): rst for 2 cycles, then din={D3=0x33333333, D2=0x22222222, D1=0x11111111, D0=0x00000000}, in_valid=1, sel=0,1,2,3 on consecutive cycles → y=0x0,0x11111111,0x22222222,0x33333333, one cycle late; y_valid=1 throughout.
- Stall/flush priority: load sel=2, then assert stall for 3 cycles while sel changes → y stays 0x22222222 with y_valid=1. Then assert stall=1 and flush=1 together → next cycle y_valid=0, y=0.
- Illegal select (NUM_IN=3, HOLD_ON_ERR=0): previous y=0xAAAA5555, then sel=3 with in_valid=1 → y=0, y_valid=0, sel_err=1, y_sel=3, err_cnt=1. Next cycle sel=1 → sel_err=0, y=din[1].
- Hold-on-error and saturation (NUM_IN=3, HOLD_ON_ERR=1, ERR_CNT_W=2): previous y=0x12345678, then 5 consecutive illegal selects → y stays 0x12345678; err_cnt=1,2,3,3,3. Then err_clr=1 together with one more illegal select → err_cnt=0.
- Gating of the counter: an illegal sel presented during stall=1, during flush=1, or with in_valid=0 → err_cnt unchanged, and sel_err is not set by that input.
- Mid-operation reset: with y_valid=1 and err_cnt=5, pulse rst for 1 cycle with in_valid=1 → next cycle all outputs are 0; loading resumes on the following cycle.
